// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler: sequences a full C = A*B GEMM as tiles (n outer, m middle, k inner) on the gemm system-bus register map.
// Ports: clk/rst (sync, active-high); start, dim_m/n/k, a/b/c_base job inputs; busy/done status; system_bus_* master; perf_cycles/perf_stall.
// Latency: 11 cycles per tile (CALC, 7 writes, FULL poll, NEXT) plus 2 per extra FULL poll; a new tile never starts while FULL reads 1.
// Optional feature macro GEMM_SCHED_PERF_EN: saturating busy/stall counters; when undefined both perf outputs are tied to 0.
module gemm_tile_scheduler #(
    parameter int unsigned BLK_M     = 16,
    parameter int unsigned BLK_N     = 16,   // SUPER_SYS_ROWS of the systolic array
    parameter int unsigned BLK_K     = 16,   // SUPER_SYS_COLS of the systolic array
    parameter int unsigned DIM_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [31:0]      a_base,
    input  logic [31:0]      b_base,
    input  logic [31:0]      c_base,
    output logic             busy,
    output logic             done,
    output logic             system_bus_en,
    output logic             system_bus_rdwr,
    output logic [31:0]      system_bus_addr,
    output logic [31:0]      system_bus_wr_data,
    input  logic [31:0]      system_bus_rd_data,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall
);
    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_WR, S_FULLRQ, S_FULLCK, S_NEXT, S_DRNRQ, S_DRNCK, S_FIN
    } state_t;

    localparam int unsigned CW = DIM_W + 1;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] dm_q, dn_q, dk_q;
    logic [DIM_W-1:0] m_q, n_q, k_q;
    logic [31:0]      a_q, b_q, c_q;
    logic [31:0]      ta_q, tb_q, tc_q;
    logic [4:0]       ms_q, ns_q, ks_q;
    logic             first_q, last_q;
    logic [2:0]       beat_q;
    logic             busy_q, done_q;
    logic [4:0]       bus_off;

    logic accept, zero_dim;
    assign accept   = (state_q == S_IDLE) && start;
    assign zero_dim = (dim_m == '0) || (dim_n == '0) || (dim_k == '0);

    // Loop advance is one bit wider so a counter near 2^DIM_W cannot wrap past its limit.
    logic [DIM_W:0] k_adv, m_adv, n_adv;
    logic           k_wrap, m_wrap, n_wrap;
    assign k_adv  = {1'b0, k_q} + CW'(BLK_K);
    assign m_adv  = {1'b0, m_q} + CW'(BLK_M);
    assign n_adv  = {1'b0, n_q} + CW'(BLK_N);
    assign k_wrap = k_adv >= {1'b0, dk_q};
    assign m_wrap = m_adv >= {1'b0, dm_q};
    assign n_wrap = n_adv >= {1'b0, dn_q};

    // Tile extents: remainder of each dimension clamped to the block size (never 0 while in range).
    logic [DIM_W-1:0] rem_m, rem_n, rem_k;
    logic [4:0]       ms_c, ns_c, ks_c;
    assign rem_m = dm_q - m_q;
    assign rem_n = dn_q - n_q;
    assign rem_k = dk_q - k_q;
    assign ms_c  = (rem_m < DIM_W'(BLK_M)) ? rem_m[4:0] : 5'(BLK_M);
    assign ns_c  = (rem_n < DIM_W'(BLK_N)) ? rem_n[4:0] : 5'(BLK_N);
    assign ks_c  = (rem_k < DIM_W'(BLK_K)) ? rem_k[4:0] : 5'(BLK_K);

    // Tile base addresses, all mod 2^32. B is addressed at the last row of the k slice.
    logic [31:0] ta_c, tb_c, tc_c;
    assign ta_c = a_q + 32'(m_q) * 32'(dk_q) + 32'(k_q);
    assign tb_c = b_q + (32'(k_q) + 32'(ks_c) - 32'd1) * 32'(dn_q) + 32'(n_q);
    assign tc_c = c_q + 32'(m_q) * 32'(dn_q) + 32'(n_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        system_bus_en      = 1'b0;
        system_bus_rdwr    = 1'b0;
        system_bus_wr_data = '0;
        bus_off            = 5'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = zero_dim ? S_FIN : S_CALC;
                end
            end
            S_CALC: state_d = S_WR;
            S_WR: begin
                system_bus_en   = 1'b1;
                system_bus_rdwr = 1'b1;
                case (beat_q)
                    3'd0:    begin bus_off = 5'd12; system_bus_wr_data = 32'(dk_q); end
                    3'd1:    begin bus_off = 5'd16; system_bus_wr_data = 32'(dn_q); end
                    3'd2:    begin bus_off = 5'd0;  system_bus_wr_data = ta_q; end
                    3'd3:    begin bus_off = 5'd4;  system_bus_wr_data = tb_q; end
                    3'd4:    begin bus_off = 5'd8;  system_bus_wr_data = tc_q; end
                    3'd5:    begin bus_off = 5'd20; system_bus_wr_data = {30'd0, first_q, last_q}; end
                    default: begin bus_off = 5'd24; system_bus_wr_data = {17'd0, ns_q, ks_q, ms_q}; end
                endcase
                if (beat_q == 3'd6) begin
                    state_d = S_FULLRQ;
                end
            end
            S_FULLRQ: begin
                system_bus_en = 1'b1;
                bus_off       = 5'd0;
                state_d       = S_FULLCK;
            end
            // Read data belongs to the request issued in the previous cycle.
            S_FULLCK: state_d = system_bus_rd_data[0] ? S_FULLRQ : S_NEXT;
            S_NEXT:   state_d = (k_wrap && m_wrap && n_wrap) ? S_DRNRQ : S_CALC;
            S_DRNRQ: begin
                system_bus_en = 1'b1;
                bus_off       = 5'd24;
                state_d       = S_DRNCK;
            end
            S_DRNCK:  state_d = system_bus_rd_data[0] ? S_FIN : S_DRNRQ;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign system_bus_addr = system_bus_en ? (BASE_ADDR + 32'(bus_off)) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_q    <= '0;
            dn_q    <= '0;
            dk_q    <= '0;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ta_q    <= '0;
            tb_q    <= '0;
            tc_q    <= '0;
            ms_q    <= '0;
            ns_q    <= '0;
            ks_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dm_q <= dim_m;
                        dn_q <= dim_n;
                        dk_q <= dim_k;
                        a_q  <= a_base;
                        b_q  <= b_base;
                        c_q  <= c_base;
                        m_q  <= '0;
                        n_q  <= '0;
                        k_q  <= '0;
                    end
                end
                S_CALC: begin
                    ms_q    <= ms_c;
                    ns_q    <= ns_c;
                    ks_q    <= ks_c;
                    first_q <= (k_q == '0);
                    last_q  <= k_wrap;
                    ta_q    <= ta_c;
                    tb_q    <= tb_c;
                    tc_q    <= tc_c;
                end
                S_NEXT: begin
                    if (k_wrap) begin
                        k_q <= '0;
                        if (m_wrap) begin
                            m_q <= '0;
                            n_q <= n_adv[DIM_W-1:0];
                        end else begin
                            m_q <= m_adv[DIM_W-1:0];
                        end
                    end else begin
                        k_q <= k_adv[DIM_W-1:0];
                    end
                end
                default: ;
            endcase
            beat_q <= (state_q == S_WR) ? beat_q + 3'd1 : 3'd0;
            // Status is registered: busy rises the cycle after the accepted start,
            // done pulses the cycle after FIN, in the same cycle busy falls.
            done_q <= (state_q == S_FIN);
            if (accept) begin
                busy_q <= 1'b1;
            end else if (state_q == S_FIN) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // Only bit 0 of the read data (FULL / DONE) is meaningful to the sequencer.
    logic unused_rd;
    assign unused_rd = ^system_bus_rd_data[31:1];

`ifdef GEMM_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_stall_q;
    logic        in_poll;
    assign in_poll = (state_q == S_FULLRQ) || (state_q == S_FULLCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (accept) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy_q && (perf_cycles_q != '1)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (in_poll && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`else
    assign perf_cycles = 32'd0;
    assign perf_stall  = 32'd0;
`endif

endmodule
